life_row_stepper: RTL and testbench
===================================

LIFE_ROW_STEPPER -- requirements
Module: life_row_stepper

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning cells per row (>=3).
REQ-002 SHALL provide parameter HEIGHT, default 8, meaning rows per frame (>=2).
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  in_row carries a current-generation row.
REQ-006 SHALL provide port in_ready  output  1  block accepts in_row this cycle.
REQ-007 SHALL provide port in_row  input  WIDTH  row cells, bit i = column i, 1 = alive.
REQ-008 SHALL provide port out_valid  output  1  out_row holds a next-generation row.
REQ-009 SHALL provide port out_ready  input  1  downstream consumes out_row this cycle.
REQ-010 SHALL provide port out_row  output  WIDTH  next-generation row, same bit order.
REQ-011 SHALL provide port out_last  output  1  out_row is row HEIGHT-1 of the frame.

Function
REQ-012 SHALL stream frames top-to-bottom, one row per in handshake (in_valid && in_ready); rows numbered 0..HEIGHT-1.
REQ-013 SHALL treat every cell outside the frame (row -1, row HEIGHT, column -1, column WIDTH) as dead; no wrap-around.
REQ-014 SHALL form each cell's neighbour count as the 4-bit unsigned sum of its 8 neighbours (range 0..8, no overflow).
REQ-015 SHALL set a next-generation cell alive iff count==3, or count==2 and the cell is currently alive.
REQ-016 SHALL hold two row buffers (previous, current), zero-initialised at frame start.
REQ-017 SHALL implement states FILL, RUN, FLUSH.
REQ-018 FILL: in_ready = !out_valid || out_ready; on handshake store row 0 as current, previous = 0, no output, go RUN.
REQ-019 RUN: in_ready = !out_valid || out_ready; on handshake of row k, compute next-gen of row k-1 from (previous, current, in_row), load output register, shift buffers; after k==HEIGHT-1 go FLUSH.
REQ-020 FLUSH: in_ready = 0; when !out_valid || out_ready, compute row HEIGHT-1 with zero row below, load output with out_last=1, clear buffers and row counter, go FILL.
REQ-021 SHALL assert out_valid in the cycle after the loading event; latency one clock from handshake of row k to out_row for row k-1.
REQ-022 SHALL hold out_row and out_last stable while out_valid && !out_ready.
REQ-023 SHALL deassert out_valid after an out handshake unless a new row is loaded the same cycle.
REQ-024 SHALL sustain one row per cycle when out_ready is held high, with one in_ready-low cycle per frame (FLUSH).
REQ-025 SHALL assert out_last only on row HEIGHT-1 output, 0 otherwise.

Reset
REQ-026 SHALL, while rst is high, drive in_ready=0, and on the clock edge set state=FILL, row counter=0, buffers=0, out_valid=0, out_row=0, out_last=0.
REQ-027 SHALL discard any partial frame and pending output on reset mid-frame; the next accepted row is row 0.

Verification
REQ-028 Blinker: WIDTH=8, HEIGHT=8, rows 2,3,4 = 0x08, others 0x00, out_ready=1 -> outputs row3=0x1C, all other rows 0x00, out_last on 8th output only.
REQ-029 Corner block: rows 0,1 = 0x03, rest 0x00 -> outputs rows 0,1 = 0x03, rest 0x00 (edge treated dead).
REQ-030 All-alive: every row 0xFF -> row0=0x81, rows1-6=0x00, row7=0x81.
REQ-031 Backpressure: out_ready=0 for 5 cycles after first output -> in_ready=0 throughout, out_row stable, no row lost or duplicated afterward.
REQ-032 Reset mid-frame: rst pulse after 4 rows accepted -> out_valid=0 next cycle; following full blinker frame yields REQ-028 results.
REQ-033 Back-to-back frames, out_ready=1, in_valid=1 -> 8 outputs per frame, in_ready low exactly one cycle between frames, frame 2 row 0 accepted the cycle after FLUSH.

Source files
------------

// File: rtl/life_row_stepper_if.sv
// Row-streaming handshake bundle for life_row_stepper: an input row channel and
// an output row channel, each with its own valid/ready pair.
interface life_row_stepper_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_row;
  logic             out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/life_row_stepper.sv
// Streams a Game-of-Life frame one row at a time and emits the next generation,
// one row behind the input, using a two-row window (previous, current).
module life_row_stepper #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic               clk,
  input  logic               rst,
  life_row_stepper_if.slave  bus
);

  localparam int              CNT_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cur;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_row;
  logic             r_out_last;

  logic             w_can_load;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_below;
  logic [WIDTH-1:0] w_next;

  // One cell per column; padding bits make the frame edges read as dead cells.
  function automatic logic [WIDTH-1:0] next_gen(
    input logic [WIDTH-1:0] above,
    input logic [WIDTH-1:0] mid,
    input logic [WIDTH-1:0] below
  );
    logic [WIDTH+1:0] a;
    logic [WIDTH+1:0] m;
    logic [WIDTH+1:0] b;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] res;
    // NOTE: blocking assignments here are correct: this is pure combinational
    // evaluation, each temporary is consumed in the same pass.
    a   = {1'b0, above, 1'b0};
    m   = {1'b0, mid,   1'b0};
    b   = {1'b0, below, 1'b0};
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = 4'(a[i]) + 4'(a[i+1]) + 4'(a[i+2])
          + 4'(m[i])              + 4'(m[i+2])
          + 4'(b[i]) + 4'(b[i+1]) + 4'(b[i+2]);
      res[i] = (cnt == 4'd3) || ((cnt == 4'd2) && mid[i]);
    end
    return res;
  endfunction

  assign w_can_load   = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !rst && (r_state != S_FLUSH) && w_can_load;
  assign w_in_fire    = bus.in_valid && bus.in_ready;

  // The row below the bottom edge is dead, so FLUSH feeds zeros.
  always_comb begin
    w_below = bus.in_row;
    if (r_state == S_FLUSH) begin
      w_below = '0;
    end
  end

  assign w_next = next_gen(r_prev, r_cur, w_below);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the row buffers are reset too, since a partial
  // frame must never leak into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_cur       <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            r_prev  <= '0;
            r_cur   <= bus.in_row;
            r_cnt   <= CNT_W'(1);
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (w_in_fire) begin
            r_out_row   <= w_next;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
            r_prev      <= r_cur;
            r_cur       <= bus.in_row;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == LAST_ROW) begin
              r_state <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          if (w_can_load) begin
            r_out_row   <= w_next;
            r_out_last  <= 1'b1;
            r_out_valid <= 1'b1;
            r_prev      <= '0;
            r_cur       <= '0;
            r_cnt       <= '0;
            r_state     <= S_FILL;
          end
        end

        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_row   = r_out_row;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_life_row_stepper.sv
// Self-checking bench for life_row_stepper: fixed pattern frames, backpressure,
// mid-frame reset, back-to-back streaming and random stalls against a grid model.
module tb_life_row_stepper;

  localparam int W = 8;
  localparam int H = 8;

  typedef logic [H-1:0][W-1:0] frame_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  life_row_stepper_if #(.WIDTH(W)) bus ();

  life_row_stepper #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int send_idx    = 0;

  logic [W-1:0] send_q[$];
  logic [W-1:0] exp_row[$];
  logic [W-1:0] got_row[$];
  bit           exp_last[$];
  bit           got_last[$];
  int           acc_cyc[$];

  logic         obs_in_ready;
  logic         obs_out_valid;
  logic [W-1:0] obs_out_row;

  // Grid-level reference: count live neighbours inside the frame bounds.
  function automatic frame_t life(input frame_t f);
    frame_t nx;
    int     n;
    int     rr;
    int     cc;
    nx = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W) begin
              if (f[rr][cc]) n++;
            end
          end
        end
        nx[r][c] = (n == 3) || (n == 2 && f[r][c]);
      end
    end
    return nx;
  endfunction

  task automatic clear_queues();
    send_q.delete();
    exp_row.delete();
    got_row.delete();
    exp_last.delete();
    got_last.delete();
    acc_cyc.delete();
    send_idx = 0;
  endtask

  task automatic queue_fixed(input frame_t fin, input frame_t fout);
    for (int r = 0; r < H; r++) begin
      send_q.push_back(fin[r]);
      exp_row.push_back(fout[r]);
      exp_last.push_back(r == H - 1);
    end
  endtask

  task automatic queue_frame(input frame_t fin);
    queue_fixed(fin, life(fin));
  endtask

  // One clock: drive at the falling edge, observe 1 ns later, record handshakes.
  task automatic step(input bit iv, input bit ordy);
    bus.in_valid  = iv && (send_idx < send_q.size());
    bus.in_row    = bus.in_valid ? send_q[send_idx] : W'($urandom);
    bus.out_ready = ordy;
    #1;
    obs_in_ready  = bus.in_ready;
    obs_out_valid = bus.out_valid;
    obs_out_row   = bus.out_row;
    if (bus.in_valid && bus.in_ready) begin
      acc_cyc.push_back(cyc);
      send_idx++;
    end
    if (bus.out_valid && bus.out_ready) begin
      got_row.push_back(bus.out_row);
      got_last.push_back(bus.out_last);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int in_pct, input int out_pct, input int budget);
    int n;
    n = 0;
    while (got_row.size() < exp_row.size() && n < budget) begin
      step($urandom_range(99) < in_pct, $urandom_range(99) < out_pct);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1);
      vectors++;
      if (obs_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset in_ready: got %b, expected 0", obs_in_ready);
      end
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_row !== '0 || bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: got valid=%b row=%h last=%b, expected 0/00/0",
               bus.out_valid, bus.out_row, bus.out_last);
    end
    rst = 1'b0;
    clear_queues();
  endtask

  task automatic test_pattern(input string name, input frame_t fin, input frame_t fout);
    clear_queues();
    queue_fixed(fin, fout);
    drain(100, 100, 100);
    vectors++;
    if (got_row.size() != exp_row.size()) begin
      miscompares++;
      $display("FAIL %s count: got %0d rows, expected %0d", name, got_row.size(), exp_row.size());
    end
    for (int i = 0; i < exp_row.size() && i < got_row.size(); i++) begin
      vectors++;
      if (got_row[i] !== exp_row[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL %s row %0d: got %h last %0b, expected %h last %0b",
                 name, i, got_row[i], got_last[i], exp_row[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_blinker();
    frame_t fin;
    frame_t fout;
    fin     = '0;
    fin[2]  = 8'h08;
    fin[3]  = 8'h08;
    fin[4]  = 8'h08;
    fout    = '0;
    fout[3] = 8'h1C;
    test_pattern("blinker", fin, fout);
  endtask

  task automatic test_corner_block();
    frame_t fin;
    fin    = '0;
    fin[0] = 8'h03;
    fin[1] = 8'h03;
    test_pattern("corner", fin, fin);
  endtask

  task automatic test_all_alive();
    frame_t fin;
    frame_t fout;
    fin     = '1;
    fout    = '0;
    fout[0] = 8'h81;
    fout[7] = 8'h81;
    test_pattern("all_alive", fin, fout);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hold;
    int           n;
    clear_queues();
    queue_frame({$urandom, $urandom});
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      step(1'b1, 1'b1);
      n++;
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp first output: got out_valid %b, expected 1", bus.out_valid);
    end
    hold = bus.out_row;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1 || obs_out_row !== hold) begin
        miscompares++;
        $display("FAIL bp stall %0d: got in_ready=%b valid=%b row=%h, expected 0/1/%h",
                 i, obs_in_ready, obs_out_valid, obs_out_row, hold);
      end
    end
    drain(100, 100, 100);
    vectors++;
    if (got_row.size() != exp_row.size()) begin
      miscompares++;
      $display("FAIL bp count: got %0d rows, expected %0d", got_row.size(), exp_row.size());
    end
    for (int i = 0; i < exp_row.size() && i < got_row.size(); i++) begin
      vectors++;
      if (got_row[i] !== exp_row[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL bp row %0d: got %h last %0b, expected %h last %0b",
                 i, got_row[i], got_last[i], exp_row[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_queues();
    queue_frame({$urandom, $urandom});
    n = 0;
    while (send_idx < 4 && n < 50) begin
      step(1'b1, 1'b1);
      n++;
    end
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    vectors++;
    if (obs_in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: got in_ready=%b out_valid=%b, expected 0/0",
               obs_in_ready, bus.out_valid);
    end
    test_blinker();
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_queues();
    for (int f = 0; f < 3; f++) queue_frame({$urandom, $urandom});
    drain(100, 100, 200);
    vectors++;
    if (got_row.size() != exp_row.size() || acc_cyc.size() != 3 * H) begin
      miscompares++;
      $display("FAIL b2b count: got %0d rows %0d accepts, expected %0d rows %0d accepts",
               got_row.size(), acc_cyc.size(), exp_row.size(), 3 * H);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      gap = (i % H == 0) ? 2 : 1;
      vectors++;
      if (acc_cyc[i] - acc_cyc[i-1] != gap) begin
        miscompares++;
        $display("FAIL b2b accept gap %0d: got %0d cycles, expected %0d",
                 i, acc_cyc[i] - acc_cyc[i-1], gap);
      end
    end
    for (int i = 0; i < exp_row.size() && i < got_row.size(); i++) begin
      vectors++;
      if (got_row[i] !== exp_row[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL b2b row %0d: got %h last %0b, expected %h last %0b",
                 i, got_row[i], got_last[i], exp_row[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random_stalls();
    clear_queues();
    for (int f = 0; f < 4; f++) queue_frame({$urandom, $urandom});
    drain(70, 60, 2000);
    vectors++;
    if (got_row.size() != exp_row.size()) begin
      miscompares++;
      $display("FAIL random count: got %0d rows, expected %0d", got_row.size(), exp_row.size());
    end
    for (int i = 0; i < exp_row.size() && i < got_row.size(); i++) begin
      vectors++;
      if (got_row[i] !== exp_row[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL random row %0d: got %h last %0b, expected %h last %0b",
                 i, got_row[i], got_last[i], exp_row[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_blinker();
    test_corner_block();
    test_all_alive();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_stalls();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
